// File: rtl/mips_instr_encoder.sv
// Program loader: encodes symbolic MIPS instruction requests and writes them
// sequentially into instruction memory, one word per two cycles.
module mips_instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_err;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;

    logic                w_legal;
    logic [31:0]         w_word;
    logic                w_ready;
    logic                w_full;

    always_comb begin
        w_legal = 1'b1;
        w_word  = '0;
        case (in_kind)
            4'd0:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            4'd1:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            4'd2:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
            4'd3:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
            4'd4:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
            4'd5:    w_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
            4'd6:    w_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
            4'd7:    w_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
            4'd8:    w_word = {6'b001000, in_rs, in_rt, in_imm[15:0]};
            4'd9:    w_word = {6'b000010, in_imm};
            default: w_legal = 1'b0;
        endcase
    end

    // count never exceeds 2^ADDR_W, so its top bit alone marks a full memory
    assign w_full   = r_count[ADDR_W];
    assign w_ready  = rst_n & (r_state == S_IDLE) & ~w_full & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (clear) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_we <= 1'b0;
                    if (in_valid && w_ready) begin
                        if (w_legal) begin
                            r_wdata <= w_word;
                            r_addr  <= r_ptr;
                            r_we    <= 1'b1;
                            r_state <= S_WRITE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_we    <= 1'b0;
                    r_ptr   <= r_ptr + 1'b1;
                    r_count <= r_count + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign full      = w_full;
    assign err       = r_err;

endmodule
